// File: rtl/hex_updown_counter.sv
// hex_updown_counter: up/down counter with a DIGITS-wide 7-segment readout.
// The raw push-button is synchronised and edge-detected on clk, so every press
// yields exactly one count tick. Parallel load has priority and is clamped to the
// legal range.
// Optional macro HEX_COUNTER_BCD_EN: decimal counting per digit (0-9 each),
// MODULUS ignored. Without it the counter is binary, modulo MODULUS.
module hex_updown_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W = 4 * DIGITS;

`ifdef HEX_COUNTER_BCD_EN
  localparam logic [W-1:0] MAX_VAL = {DIGITS{4'h9}};
`else
  localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);
`endif

  logic         sync1_reg, sync2_reg, hist_reg;
  logic [1:0]   warm_reg;
  logic         armed_reg;
  logic         tick;
  logic [W-1:0] count_reg;
  logic         tc_reg;
  logic [W-1:0] inc_val, dec_val, load_clamp;

  // Active-low segment code (gfedcba) for one nibble.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Button synchroniser, history flop and post-reset arming.
  // warm_reg marks when sync2_reg holds a genuinely sampled button level; the
  // detector only arms once the button has been seen released, so a button held
  // through reset release cannot produce a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      hist_reg  <= 1'b1;
      warm_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync1_reg <= step;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      warm_reg  <= {warm_reg[0], 1'b1};
      armed_reg <= armed_reg | (warm_reg[1] & sync2_reg);
    end
  end

  // One-cycle pulse on a 1->0 transition of the synchronised button.
  assign tick = armed_reg & hist_reg & ~sync2_reg;

`ifdef HEX_COUNTER_BCD_EN
  logic [DIGITS:0] carry, borrow;
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Per-digit decimal increment/decrement chains and per-digit load clamp.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
    logic [3:0] d, ld;
    assign d  = count_reg[4*gi +: 4];
    assign ld = load_val[4*gi +: 4];
    assign inc_val[4*gi +: 4]    = carry[gi]  ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign dec_val[4*gi +: 4]    = borrow[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    assign carry[gi+1]           = carry[gi]  & (d == 4'd9);
    assign borrow[gi+1]          = borrow[gi] & (d == 4'd0);
    assign load_clamp[4*gi +: 4] = (ld > 4'd9) ? 4'd9 : ld;
  end
`else
  assign inc_val    = count_reg + W'(1);
  assign dec_val    = count_reg - W'(1);
  assign load_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;
`endif

  // Count register: load beats a tick, a tick with en counts, otherwise hold.
  // tc is raised only on the update that wraps the range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      tc_reg <= 1'b0;
      if (load) begin
        count_reg <= load_clamp;
      end else if (tick && en) begin
        if (up) begin
          if (count_reg == MAX_VAL) begin
            count_reg <= '0;
            tc_reg    <= 1'b1;
          end else begin
            count_reg <= inc_val;
          end
        end else begin
          if (count_reg == '0) begin
            count_reg <= MAX_VAL;
            tc_reg    <= 1'b1;
          end else begin
            count_reg <= dec_val;
          end
        end
      end
    end
  end

  // Combinational segment decode, one display per digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
    assign hex[7*gi +: 7] = seg7(count_reg[4*gi +: 4]);
  end

  assign count = count_reg;
  assign tc    = tc_reg;

endmodule

// File: tb/tb_hex_updown_counter.sv
// Directed bench for hex_updown_counter (DIGITS=2). Expectations follow the
// binary build by default and the decimal build when HEX_COUNTER_BCD_EN is set.
module tb_hex_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  count;
  logic        tc;
  logic [13:0] hex;

  logic        load2 = 1'b0;
  logic [7:0]  load_val2 = 8'h00;
  logic [7:0]  count2;
  logic        tc2;
  logic [13:0] hex2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HEX_COUNTER_BCD_EN
  localparam logic [7:0]  MAXV     = 8'h99;
  localparam logic [13:0] HEX_MAXV = 14'h0810;
`else
  localparam logic [7:0]  MAXV     = 8'hFF;
  localparam logic [13:0] HEX_MAXV = 14'h070E;
`endif

  hex_updown_counter #(.DIGITS(2), .MODULUS(256)) dut (
    .clk(clk), .rst(rst), .step(step), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .hex(hex)
  );

  hex_updown_counter #(.DIGITS(2), .MODULUS(100)) dut100 (
    .clk(clk), .rst(rst), .step(1'b1), .en(1'b0), .up(1'b1), .load(load2),
    .load_val(load_val2), .count(count2), .tc(tc2), .hex(hex2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One press: count must still be old after 2 edges, new after the 3rd.
  task automatic press(input string tag, input logic [7:0] exp, input logic exp_tc);
    logic [7:0] old;
    old  = count;
    step = 1'b0;
    cyc(2);
    check({tag, " early"}, count, old);
    cyc(1);
    check({tag, " count"}, count, exp);
    check({tag, " tc"}, tc, exp_tc);
    step = 1'b1;
    cyc(1);
    check({tag, " tc clr"}, tc, 1'b0);
    cyc(3);
  endtask

  task automatic do_load(input string tag, input logic [7:0] v, input logic [7:0] exp);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
    check({tag, " count"}, count, exp);
    check({tag, " tc"}, tc, 1'b0);
  endtask

  task automatic load100(input string tag, input logic [7:0] v, input logic [7:0] exp);
    load2     = 1'b1;
    load_val2 = v;
    cyc(1);
    load2 = 1'b0;
    check(tag, count2, exp);
  endtask

  initial begin
    // 1: reset state
    cyc(2);
    rst = 1'b1;
    cyc(4);
    check("rst count", count, 8'h00);
    check("rst tc", tc, 1'b0);
    check("rst hex", hex, 14'h2040);

    // 2: three presses up, then holding the button gives no extra count
    en = 1'b1; up = 1'b1;
    press("up1", 8'h01, 1'b0);
    press("up2", 8'h02, 1'b0);
    press("up3", 8'h03, 1'b0);
    check("hex 03", hex, 14'h2030);
    step = 1'b0;
    cyc(103);
    check("hold low", count, 8'h04);
    step = 1'b1;
    cyc(3);
    check("release", count, 8'h04);

    // 3: wrap up through max
`ifdef HEX_COUNTER_BCD_EN
    do_load("ld99", 8'h99, 8'h99);
    press("wrap up", 8'h00, 1'b1);
    check("wrap hex", hex, 14'h2040);
    do_load("ldAF", 8'hAF, 8'h99);
    do_load("ld19", 8'h19, 8'h19);
    press("dec carry", 8'h20, 1'b0);
    up = 1'b0;
    press("dec borrow", 8'h19, 1'b0);
    up = 1'b1;
`else
    do_load("ldFE", 8'hFE, 8'hFE);
    press("to FF", 8'hFF, 1'b0);
    press("wrap up", 8'h00, 1'b1);
    check("wrap hex", hex, 14'h2040);
`endif

    // 4: wrap down from zero, en=0 blocks the count
    do_load("ld00", 8'h00, 8'h00);
    up = 1'b0;
    press("wrap dn", MAXV, 1'b1);
    check("hex max", hex, HEX_MAXV);
    en = 1'b0;
    press("en off", MAXV, 1'b0);
    en = 1'b1;
    press("down", MAXV - 8'h01, 1'b0);

    // 5: load in the same cycle as a tick wins and drops the tick
    step = 1'b0;
    cyc(2);
    load = 1'b1; load_val = 8'h5A;
    cyc(1);
    load = 1'b0;
    step = 1'b1;
`ifdef HEX_COUNTER_BCD_EN
    check("ld+tick", count, 8'h59);
    cyc(4);
    check("tick dropped", count, 8'h59);
    check("hex 59", hex, 14'h0910);
`else
    check("ld+tick", count, 8'h5A);
    cyc(4);
    check("tick dropped", count, 8'h5A);
    check("hex 5A", hex, 14'h0908);
    load100("m100 200", 8'd200, 8'd99);
    load100("m100 100", 8'd100, 8'd99);
    load100("m100 50", 8'd50, 8'd50);
`endif

    // Reset while the button is held: no tick on release of rst
    rst  = 1'b0;
    step = 1'b0;
    #1;
    check("async rst", count, 8'h00);
    cyc(2);
    rst = 1'b1;
    cyc(10);
    check("no tick rst", count, 8'h00);
    step = 1'b1;
    cyc(4);
    up = 1'b1;
    press("after rst", 8'h01, 1'b0);

    // 6: reset mid-press clears immediately
    do_load("ld42", 8'h42, 8'h42);
    step = 1'b0;
    cyc(1);
    rst = 1'b0;
    #1;
    check("rst mid", count, 8'h00);
    check("rst mid hex", hex, 14'h2040);
    step = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(6);
    check("post rst", count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulation time in case a wait ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
